axis_resizer: RTL and testbench

AXI-Stream width converter that carries a packetised sample stream between an input bus of `DWIDTH_IN` bits and an output bus of `DWIDTH_OUT` bits with no loss, duplication or reordering of data.
- Internally it is an upsizer (pack `UP` input words) followed by a downsizer (split into `DOWN` output words).
- Both stages are usable standalone by setting one ratio to 1.
- It sits between processing blocks whose sample-bus widths differ.

---
 rtl/axis_resizer_if.sv | 12 +
 rtl/axis_resizer.sv | 139 +++++++++++++
 tb/tb_axis_resizer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_resizer_if.sv
// AXI-Stream bundle: data, valid, last forward; ready backward.
interface axis_resizer_if #(
  parameter int unsigned DWIDTH = 8
);
  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_resizer.sv
// AXI-Stream width converter: pack UP input words into an LCM-wide word,
// then split it into DOWN output words. LSB-first subword order.
module axis_resizer #(
  parameter int unsigned DWIDTH_IN  = 24,
  parameter int unsigned DWIDTH_OUT = 32
) (
  input  logic           clk,
  input  logic           reset,
  axis_resizer_if.slave  data_in,
  axis_resizer_if.master data_out
);

  function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
    int unsigned x;
    int unsigned y;
    int unsigned t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  localparam int unsigned G    = gcd(DWIDTH_IN, DWIDTH_OUT);
  localparam int unsigned UP   = DWIDTH_OUT / G;
  localparam int unsigned DOWN = DWIDTH_IN / G;
  localparam int unsigned LCM  = DWIDTH_IN * UP;
  localparam int unsigned CW   = (UP > 1) ? $clog2(UP) : 1;
  localparam int unsigned IW   = (DOWN > 1) ? $clog2(DOWN) : 1;

  // Link between the two stages (LCM-wide stream).
  logic [LCM-1:0] up_data;
  logic           up_valid;
  logic           up_last;
  logic           up_ready;

  if (UP > 1) begin : g_up
    logic [LCM-1:0] acc;
    logic [CW-1:0]  count;
    logic [LCM-1:0] st_data;
    logic           st_valid;
    logic           st_last;
    logic           in_ok_c;
    logic           flush_c;
    logic [LCM-1:0] pack_c;

    // Slots at and above count are always zero in acc, so OR-ing places the
    // new word and leaves zero padding above it on a partial flush.
    assign in_ok_c = data_in.valid && data_in.ready;
    assign flush_c = (count == CW'(UP - 1)) || data_in.last;
    assign pack_c  = acc | (LCM'(data_in.data) << (DWIDTH_IN * 32'(count)));

    assign data_in.ready = !reset && (!st_valid || up_ready);
    assign up_data       = st_data;
    assign up_valid      = st_valid;
    assign up_last       = st_last;

    // Accumulate input words; hand the packed word to the stage register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc      <= '0;
        count    <= '0;
        st_data  <= '0;
        st_valid <= 1'b0;
        st_last  <= 1'b0;
      end else begin
        if (st_valid && up_ready) begin
          st_valid <= 1'b0;
        end
        if (in_ok_c) begin
          if (flush_c) begin
            acc      <= '0;
            count    <= '0;
            st_data  <= pack_c;
            st_valid <= 1'b1;
            st_last  <= data_in.last;
          end else begin
            acc   <= pack_c;
            count <= count + CW'(1);
          end
        end
      end
    end
  end else begin : g_up_bypass
    assign up_data       = LCM'(data_in.data);
    assign up_valid      = data_in.valid;
    assign up_last       = data_in.last;
    assign data_in.ready = !reset && up_ready;
  end

  // The 1:1 case keeps this stage as a plain register slice.
  if (DOWN > 1 || UP == 1) begin : g_dn
    logic [LCM-1:0] hold;
    logic           hold_last;
    logic [IW-1:0]  idx;
    logic           dn_valid;
    logic           last_sub_c;

    assign last_sub_c    = (idx == IW'(DOWN - 1));
    assign up_ready      = !dn_valid || (data_out.ready && last_sub_c);
    assign data_out.data = DWIDTH_OUT'(hold >> (DWIDTH_OUT * 32'(idx)));
    assign data_out.valid = dn_valid;
    assign data_out.last = hold_last && last_sub_c;

    // Step through subwords; reload in the same cycle the final one leaves.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold      <= '0;
        hold_last <= 1'b0;
        idx       <= '0;
        dn_valid  <= 1'b0;
      end else begin
        if (dn_valid && data_out.ready) begin
          if (last_sub_c) begin
            dn_valid <= 1'b0;
            idx      <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        if (up_valid && up_ready) begin
          hold      <= up_data;
          hold_last <= up_last;
          idx       <= '0;
          dn_valid  <= 1'b1;
        end
      end
    end
  end else begin : g_dn_bypass
    assign data_out.data  = DWIDTH_OUT'(up_data);
    assign data_out.valid = up_valid;
    assign data_out.last  = up_last;
    assign up_ready       = data_out.ready;
  end

endmodule

// File: tb/tb_axis_resizer.sv
// Bench for axis_resizer: four widths (256->64, 16->128, 24->32, 24->24).
module tb_axis_resizer;
  localparam int unsigned WMAX = 256;
  localparam int NPKT = 50;
  typedef logic [WMAX-1:0] word_t;
  typedef logic [WMAX:0]   cmp_t;
  typedef struct { word_t d; logic l; int cyc; } beat_t;
  typedef struct { int u; bit is_out; word_t d; logic l; } vec_t;

  int IB [4] = '{32, 2, 3, 3};   // input bytes per word
  int OB [4] = '{8, 16, 4, 3};   // output bytes per word
  int LB [4] = '{32, 16, 12, 3}; // LCM bytes

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rmode [4] = '{1, 1, 1, 1};
  beat_t oq0[$], oq1[$], oq2[$], oq3[$];
  vec_t  vq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_resizer_if #(.DWIDTH(256)) i0i ();
  axis_resizer_if #(.DWIDTH(64))  i0o ();
  axis_resizer_if #(.DWIDTH(16))  i1i ();
  axis_resizer_if #(.DWIDTH(128)) i1o ();
  axis_resizer_if #(.DWIDTH(24))  i2i ();
  axis_resizer_if #(.DWIDTH(32))  i2o ();
  axis_resizer_if #(.DWIDTH(24))  i3i ();
  axis_resizer_if #(.DWIDTH(24))  i3o ();

  axis_resizer #(.DWIDTH_IN(256), .DWIDTH_OUT(64))  u0 (.clk(clk), .reset(reset), .data_in(i0i), .data_out(i0o));
  axis_resizer #(.DWIDTH_IN(16),  .DWIDTH_OUT(128)) u1 (.clk(clk), .reset(reset), .data_in(i1i), .data_out(i1o));
  axis_resizer #(.DWIDTH_IN(24),  .DWIDTH_OUT(32))  u2 (.clk(clk), .reset(reset), .data_in(i2i), .data_out(i2o));
  axis_resizer #(.DWIDTH_IN(24),  .DWIDTH_OUT(24))  u3 (.clk(clk), .reset(reset), .data_in(i3i), .data_out(i3o));

  function automatic logic pick(input int m);
    if (m == 2) return 1'($urandom_range(0, 1));
    return (m == 1);
  endfunction

  // Output ready per unit: 0 = held low, 1 = high, 2 = random.
  always @(posedge clk) begin
    #1;
    i0o.ready = pick(rmode[0]);
    i1o.ready = pick(rmode[1]);
    i2o.ready = pick(rmode[2]);
    i3o.ready = pick(rmode[3]);
  end

  // Record every output transfer (valid & ready) with its cycle number.
  always @(negedge clk) begin
    if (!reset) begin
      if (i0o.valid && i0o.ready) oq0.push_back('{word_t'(i0o.data), i0o.last, cyc});
      if (i1o.valid && i1o.ready) oq1.push_back('{word_t'(i1o.data), i1o.last, cyc});
      if (i2o.valid && i2o.ready) oq2.push_back('{word_t'(i2o.data), i2o.last, cyc});
      if (i3o.valid && i3o.ready) oq3.push_back('{word_t'(i3o.data), i3o.last, cyc});
    end
  end

  function automatic int qsize(input int u);
    case (u)
      0: return oq0.size();
      1: return oq1.size();
      2: return oq2.size();
      default: return oq3.size();
    endcase
  endfunction

  function automatic beat_t qpop(input int u);
    case (u)
      0: return oq0.pop_front();
      1: return oq1.pop_front();
      2: return oq2.pop_front();
      default: return oq3.pop_front();
    endcase
  endfunction

  function automatic logic in_ready(input int u);
    case (u)
      0: return i0i.ready;
      1: return i1i.ready;
      2: return i2i.ready;
      default: return i3i.ready;
    endcase
  endfunction

  function automatic logic out_valid(input int u);
    case (u)
      0: return i0o.valid;
      1: return i1o.valid;
      2: return i2o.valid;
      default: return i3o.valid;
    endcase
  endfunction

  function automatic cmp_t out_dl(input int u);
    case (u)
      0: return {i0o.last, word_t'(i0o.data)};
      1: return {i1o.last, word_t'(i1o.data)};
      2: return {i2o.last, word_t'(i2o.data)};
      default: return {i3o.last, word_t'(i3o.data)};
    endcase
  endfunction

  task automatic set_in(input int u, input word_t d, input logic l, input logic v);
    case (u)
      0: begin i0i.data = d;        i0i.last = l; i0i.valid = v; end
      1: begin i1i.data = d[15:0];  i1i.last = l; i1i.valid = v; end
      2: begin i2i.data = d[23:0];  i2i.last = l; i2i.valid = v; end
      default: begin i3i.data = d[23:0]; i3i.last = l; i3i.valid = v; end
    endcase
  endtask

  task automatic idle(input int u);
    set_in(u, '0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input cmp_t act, input cmp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Present a word and hold it until accepted; acc_cyc is the acceptance cycle.
  task automatic send(input int u, input word_t d, input logic l, output int acc_cyc);
    bit   done;
    int   n;
    logic r;
    done = 0;
    n = 0;
    acc_cyc = 0;
    set_in(u, d, l, 1'b1);
    while (!done) begin
      @(negedge clk);
      r = in_ready(u);
      acc_cyc = cyc;
      tick();
      n++;
      if (r) done = 1;
      else if (n > 2000) begin
        timeout($sformatf("send_u%0d", u));
        done = 1;
      end
    end
  endtask

  task automatic pop_beat(input int u, output beat_t b, output bit got);
    int n;
    n = 0;
    got = 0;
    b = '{'0, 1'b0, 0};
    while (!got && n < 600) begin
      if (qsize(u) > 0) begin
        b = qpop(u);
        got = 1;
      end else begin
        @(posedge clk);
        #2;
        n++;
      end
    end
  endtask

  task automatic expect_beat(input string name, input int u, input word_t d, input logic l, output int bc);
    beat_t b;
    bit got;
    pop_beat(u, b, got);
    bc = b.cyc;
    if (!got) timeout(name);
    else check(name, {b.l, b.d}, {l, d});
  endtask

  task automatic add(input int u, input bit o, input word_t d, input logic l);
    vq.push_back('{u, o, d, l});
  endtask

  // Random packets with input gaps and output backpressure, byte scoreboard.
  task automatic rand_unit(input int u);
    logic [7:0] eb[$];
    bit ee[$];
    word_t d, ew;
    logic el;
    beat_t b;
    int a, n, waitc, nb, extra;
    for (int p = 0; p < NPKT; p++) begin
      n = $urandom_range(3, 100);
      for (int w = 0; w < n; w++) begin
        d = '0;
        for (int k = 0; k < IB[u]; k++) begin
          d[8*k +: 8] = 8'($urandom);
          eb.push_back(d[8*k +: 8]);
          ee.push_back(1'b0);
        end
        send(u, d, logic'(w == n - 1), a);
        if ($urandom_range(0, 3) == 0) begin
          idle(u);
          repeat ($urandom_range(1, 3)) tick();
        end
      end
      while ((eb.size() % LB[u]) != 0) begin
        eb.push_back(8'h00);
        ee.push_back(1'b0);
      end
      ee[ee.size() - 1] = 1'b1;
    end
    idle(u);
    waitc = 0;
    while (qsize(u) * OB[u] < eb.size() && waitc < 20000) begin
      tick();
      waitc++;
    end
    repeat (8) tick();
    nb = 0;
    extra = 0;
    while (qsize(u) > 0) begin
      b = qpop(u);
      if (eb.size() == 0) extra++;
      ew = '0;
      el = 1'b0;
      for (int k = 0; k < OB[u]; k++) begin
        if (eb.size() > 0) begin
          ew[8*k +: 8] = eb.pop_front();
          el = ee.pop_front();
        end
      end
      check($sformatf("rnd_u%0d_beat%0d", u, nb), {b.l, b.d}, {el, ew});
      nb++;
    end
    check($sformatf("rnd_u%0d_missing_bytes", u), cmp_t'(eb.size()), '0);
    check($sformatf("rnd_u%0d_extra_beats", u), cmp_t'(extra), '0);
  endtask

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w0, w1, wd;
    int a, a1, a2, a4, a8, bc;
    beat_t b;
    bit got;

    reset = 1'b1;
    for (int u = 0; u < 4; u++) idle(u);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      check($sformatf("rst_out_u%0d", u), out_dl(u), '0);
      check($sformatf("rst_valid_u%0d", u), cmp_t'(out_valid(u)), '0);
      check($sformatf("rst_in_ready_u%0d", u), cmp_t'(in_ready(u)), '0);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 4; u++) check($sformatf("rel_in_ready_u%0d", u), cmp_t'(in_ready(u)), cmp_t'(1));
    tick();
    tick();

    // Directed vectors: input words and expected output beats.
    w0 = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
    add(0, 0, w0, 1'b1);
    add(0, 1, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    add(0, 1, 64'hBBBBBBBBBBBBBBBB, 1'b0);
    add(0, 1, 64'hCCCCCCCCCCCCCCCC, 1'b0);
    add(0, 1, 64'hDDDDDDDDDDDDDDDD, 1'b1);
    for (int k = 1; k <= 8; k++) add(1, 0, word_t'(k), 1'b0);
    add(1, 1, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0);
    add(1, 0, 16'h0009, 1'b0);
    add(1, 0, 16'h000A, 1'b0);
    add(1, 0, 16'h000B, 1'b1);
    add(1, 1, 128'h0000_0000_0000_0000_0000_000B_000A_0009, 1'b1);
    add(2, 0, 24'h030201, 1'b0);
    add(2, 0, 24'h060504, 1'b0);
    add(2, 0, 24'h090807, 1'b0);
    add(2, 0, 24'h0C0B0A, 1'b0);
    add(2, 1, 32'h04030201, 1'b0);
    add(2, 1, 32'h08070605, 1'b0);
    add(2, 1, 32'h0C0B0A09, 1'b0);
    add(2, 0, 24'h0F0E0D, 1'b0);
    add(2, 0, 24'h121110, 1'b1);
    add(2, 1, 32'h100F0E0D, 1'b0);
    add(2, 1, 32'h00001211, 1'b0);
    add(2, 1, 32'h00000000, 1'b1);
    add(3, 0, 24'hABCDEF, 1'b0);
    add(3, 1, 24'hABCDEF, 1'b0);
    add(3, 0, 24'h123456, 1'b1);
    add(3, 1, 24'h123456, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      if (!vq[i].is_out) begin
        send(vq[i].u, vq[i].d, vq[i].l, a);
        if (i + 1 >= vq.size() || vq[i+1].is_out || vq[i+1].u != vq[i].u) idle(vq[i].u);
      end else begin
        expect_beat($sformatf("vec%0d", i), vq[i].u, vq[i].d, vq[i].l, bc);
      end
    end
    repeat (4) tick();

    // Downsizer: back-to-back words stream with no bubble, last on lane 3.
    oq0.delete();
    w1 = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    send(0, w0, 1'b1, a1);
    send(0, w1, 1'b1, a2);
    idle(0);
    check("ds_reload_cycle", cmp_t'(a2), cmp_t'(a1 + 4));
    for (int i = 0; i < 8; i++) begin
      wd = (i < 4) ? w0 : w1;
      expect_beat($sformatf("ds_lane%0d", i), 0, word_t'(wd[64*(i%4) +: 64]), logic'(i == 3 || i == 7), bc);
      check($sformatf("ds_lane%0d_cycle", i), cmp_t'(bc), cmp_t'(a1 + 1 + i));
    end

    // Upsizer: one word per cycle, output one cycle after the 8th word.
    oq1.delete();
    for (int k = 1; k <= 8; k++) begin
      send(1, word_t'(16'h0010 + k), 1'b0, a);
      if (k == 1) a1 = a;
      a8 = a;
    end
    idle(1);
    check("us_in_rate", cmp_t'(a8), cmp_t'(a1 + 7));
    expect_beat("us_word", 1, 128'h0018_0017_0016_0015_0014_0013_0012_0011, 1'b0, bc);
    check("us_latency", cmp_t'(bc), cmp_t'(a8 + 1));

    // Combined 24->32: first subword two cycles after the completing input.
    oq2.delete();
    send(2, 24'hA3A2A1, 1'b0, a);
    send(2, 24'hA6A5A4, 1'b0, a);
    send(2, 24'hA9A8A7, 1'b0, a);
    send(2, 24'hACABAA, 1'b0, a4);
    idle(2);
    expect_beat("cmb_w0", 2, 32'hA4A3A2A1, 1'b0, bc);
    check("cmb_latency", cmp_t'(bc), cmp_t'(a4 + 2));
    expect_beat("cmb_w1", 2, 32'hA8A7A6A5, 1'b0, bc);
    expect_beat("cmb_w2", 2, 32'hACABAAA9, 1'b0, bc);

    // Reset mid-packet: held output and partial upsizer data are discarded.
    rmode[0] = 0;
    repeat (2) tick();
    oq0.delete();
    oq2.delete();
    send(0, w1, 1'b1, a);
    idle(0);
    send(2, 24'hEEEEEE, 1'b0, a);
    send(2, 24'hDDDDDD, 1'b0, a);
    idle(2);
    tick();
    check("pre_rst_valid_u0", cmp_t'(out_valid(0)), cmp_t'(1));
    reset = 1'b1;
    #1;
    check("mid_rst_valid_u0", cmp_t'(out_valid(0)), '0);
    check("mid_rst_out_u0", out_dl(0), '0);
    check("mid_rst_in_ready_u2", cmp_t'(in_ready(2)), '0);
    tick();
    reset = 1'b0;
    rmode[0] = 1;
    repeat (2) tick();
    send(2, 24'hB3B2B1, 1'b0, a);
    send(2, 24'hB6B5B4, 1'b0, a);
    send(2, 24'hB9B8B7, 1'b0, a);
    send(2, 24'hBCBBBA, 1'b0, a);
    idle(2);
    repeat (10) tick();
    check("post_rst_count_u2", cmp_t'(oq2.size()), cmp_t'(3));
    check("post_rst_count_u0", cmp_t'(oq0.size()), '0);
    expect_beat("post_rst_w0", 2, 32'hB4B3B2B1, 1'b0, bc);
    expect_beat("post_rst_w1", 2, 32'hB8B7B6B5, 1'b0, bc);
    expect_beat("post_rst_w2", 2, 32'hBCBBBAB9, 1'b0, bc);

    // Random packets on all four configurations in parallel.
    for (int u = 0; u < 4; u++) rmode[u] = 2;
    repeat (3) tick();
    oq0.delete();
    oq1.delete();
    oq2.delete();
    oq3.delete();
    fork
      rand_unit(0);
      rand_unit(1);
      rand_unit(2);
      rand_unit(3);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
